fft_seq_ctrl: RTL and testbench
===============================

FFT_SEQ_CTRL -- requirements
Module: fft_seq_ctrl

Interface
REQ-001 SHALL have parameter BF_LAT, default 2, butterfly read-to-write latency in cycles (legal 1..15).
REQ-002 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have port start  in  1  frame loaded in cache, begin FFT.
REQ-005 SHALL have port abort  in  1  terminate frame, return to IDLE.
REQ-006 SHALL have port ob_ready  in  1  output consumer accepts one bin.
REQ-007 SHALL have port busy  out  1  high in every state except IDLE.
REQ-008 SHALL have ports rd_en  out  1, and rd_addr0..rd_addr3  out  8 each: butterfly operand read.
REQ-009 SHALL have ports stage  out  2, and sub_stage  out  6: twiddle index, aligned with rd_en.
REQ-010 SHALL have ports wr_en  out  1, and wr_addr0..wr_addr3  out  8 each: in-place write-back.
REQ-011 SHALL have ports ob_valid  out  1, ob_addr  out  8, and ob_last  out  1: digit-reversed readout.
REQ-012 SHALL have port done  out  1  one-cycle frame-complete pulse.
REQ-013 SHALL have port frame_cycles  out  16  cycles used by last frame.

Function
REQ-014 SHALL implement states IDLE, RUN, DRAIN, OUT, DONE.
REQ-015 IDLE: start=1 -> RUN next cycle, stage=0, sub_stage=0; start ignored in other states.
REQ-016 RUN: rd_en=1 every cycle, sub_stage j increments; j=63 -> DRAIN.
REQ-017 Read addresses SHALL be: stage0 addr0={2'b00,j}, offset 64; stage1 {j[5:4],2'b00,j[3:0]}, offset 16; stage2 {j[5:2],2'b00,j[1:0]}, offset 4; stage3 {j,2'b00}, offset 1.
REQ-018 rd_addrk SHALL equal addr0 + k*offset, 8-bit, no wrap occurring.
REQ-019 wr_en and wr_addr0..3 SHALL repeat rd_en and rd_addr0..3 exactly BF_LAT cycles later, via a BF_LAT-deep shift register.
REQ-020 DRAIN SHALL last exactly BF_LAT cycles, rd_en=0; then stage<3 -> RUN with stage+1 and j=0, stage=3 -> OUT.
REQ-021 The first read of stage s+1 SHALL occur the cycle after the last write of stage s, so there is no read-before-write hazard.
REQ-022 OUT: ob_valid=1; ob_addr = {c[1:0],c[3:2],c[5:4],c[7:6]} of counter c; c advances only when ob_valid&&ob_ready.
REQ-023 ob_last SHALL be 1 when c=255; handshake at c=255 -> DONE.
REQ-024 DONE: done=1 for one cycle, then IDLE; start in DONE is ignored.
REQ-025 Compute phase SHALL be exactly 4*(64+BF_LAT) cycles; rd_en and wr_en SHALL never be high outside RUN/DRAIN.
REQ-026 abort=1 in any state SHALL force IDLE next cycle, clear the write shift register (no wr_en afterwards), and give no done pulse; abort has priority over start.
REQ-027 Outside their active states, stage, sub_stage and all address outputs SHALL read 0.

Reset
REQ-028 rst=1 SHALL force IDLE and zero every output, counter and shift-register stage on the next edge.
REQ-029 Reset mid-frame SHALL behave as abort; no wr_en may appear after reset deasserts.
REQ-030 rst SHALL take priority over abort and start.

Configuration
REQ-031 Macro FFT_SEQ_CYCLE_CNT_EN defined: a 16-bit counter SHALL clear on start acceptance and increment each non-IDLE cycle, saturating at 16'hFFFF; frame_cycles SHALL load it on DONE and hold it until the next DONE.
REQ-032 Macro undefined: there SHALL be no counter logic, and frame_cycles SHALL be constant 0.

Verification
REQ-033 BF_LAT=2, start pulse, ob_ready=1 -> rd_en high cycles 1-64, wr_en high cycles 3-66, second-stage rd starts cycle 67, done at cycle 4*66+256+2.
REQ-034 Stage1 at j=0x25 -> rd_addr0..3 = 0x85,0x95,0xA5,0xB5; stage3 at j=0x25 -> 0x94,0x95,0x96,0x97.
REQ-035 OUT with c=1 -> ob_addr=0x40; c=0x1B -> ob_addr=0xE4; ob_last only at c=255.
REQ-036 ob_ready toggled 0/1 each cycle -> each ob_addr held until accepted, 256 handshakes, one done pulse.
REQ-037 abort asserted in DRAIN of stage2 -> IDLE next cycle, no further wr_en, busy=0, no done; a new start then runs a full frame.
REQ-038 Macro defined with ob_ready=1 and BF_LAT=2 -> frame_cycles=520 after done; macro undefined -> frame_cycles=0.

Source files
------------

// File: rtl/fft_seq_ctrl.sv
// Sequencer for a 256-point radix-4 in-place FFT: four butterfly stages, write-back pipeline, digit-reversed readout.
// Optional frame cycle counter enabled by defining FFT_SEQ_CYCLE_CNT_EN.
module fft_seq_ctrl #(
  parameter int unsigned BF_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        ob_ready,
  output logic        busy,
  output logic        rd_en,
  output logic [7:0]  rd_addr0,
  output logic [7:0]  rd_addr1,
  output logic [7:0]  rd_addr2,
  output logic [7:0]  rd_addr3,
  output logic [1:0]  stage,
  output logic [5:0]  sub_stage,
  output logic        wr_en,
  output logic [7:0]  wr_addr0,
  output logic [7:0]  wr_addr1,
  output logic [7:0]  wr_addr2,
  output logic [7:0]  wr_addr3,
  output logic        ob_valid,
  output logic [7:0]  ob_addr,
  output logic        ob_last,
  output logic        done,
  output logic [15:0] frame_cycles
);

  localparam int unsigned AW = 8;
  localparam int unsigned JW = 6;
  localparam int unsigned SW = 2;
  localparam int unsigned PW = 1 + 4 * AW;
  localparam logic [3:0]  DRAIN_LAST = 4'(BF_LAT - 1);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, OUT, DONE} state_t;

  state_t        state;
  logic [SW-1:0] stg;
  logic [JW-1:0] j;
  logic [3:0]    dcnt;
  logic [AW-1:0] c;
  logic [PW-1:0] pipe [BF_LAT];

  logic          iss_c;
  logic [SW-1:0] iss_stage_c;
  logic [JW-1:0] iss_sub_c;
  logic          hs_last_c;

  // Four butterfly operand addresses {a3,a2,a1,a0} for stage s, butterfly jj.
  function automatic logic [4*AW-1:0] rd_addrs(input logic [SW-1:0] s, input logic [JW-1:0] jj);
    logic [AW-1:0] a0, a1, a2, a3, off;
    case (s)
      2'd0:    begin a0 = {2'b00, jj};                off = 8'd64; end
      2'd1:    begin a0 = {jj[5:4], 2'b00, jj[3:0]};  off = 8'd16; end
      2'd2:    begin a0 = {jj[5:2], 2'b00, jj[1:0]};  off = 8'd4;  end
      default: begin a0 = {jj, 2'b00};                off = 8'd1;  end
    endcase
    a1 = a0 + off;
    a2 = a1 + off;
    a3 = a2 + off;
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [AW-1:0] digit_rev(input logic [AW-1:0] v);
    return {v[1:0], v[3:2], v[5:4], v[7:6]};
  endfunction

  // Which butterfly read (if any) is issued on the coming edge.
  always_comb begin
    iss_c       = 1'b0;
    iss_stage_c = stg;
    iss_sub_c   = '0;
    case (state)
      IDLE:  if (start) begin
               iss_c       = 1'b1;
               iss_stage_c = '0;
             end
      RUN:   if (j != 6'd63) begin
               iss_c     = 1'b1;
               iss_sub_c = j + 6'd1;
             end
      DRAIN: if (dcnt == DRAIN_LAST && stg != 2'd3) begin
               iss_c       = 1'b1;
               iss_stage_c = stg + 2'd1;
             end
      default: ;
    endcase
  end

  assign hs_last_c = (state == OUT) && ob_valid && ob_ready && (c == 8'hFF);

  assign {wr_en, wr_addr3, wr_addr2, wr_addr1, wr_addr0} = pipe[BF_LAT-1];

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state     <= IDLE;
      stg       <= '0;
      j         <= '0;
      dcnt      <= '0;
      c         <= '0;
      busy      <= 1'b0;
      rd_en     <= 1'b0;
      stage     <= '0;
      sub_stage <= '0;
      rd_addr0  <= '0;
      rd_addr1  <= '0;
      rd_addr2  <= '0;
      rd_addr3  <= '0;
      ob_valid  <= 1'b0;
      ob_addr   <= '0;
      ob_last   <= 1'b0;
      done      <= 1'b0;
      for (int i = 0; i < BF_LAT; i++) pipe[i] <= '0;
    end else begin
      rd_en     <= iss_c;
      stage     <= iss_c ? iss_stage_c : '0;
      sub_stage <= iss_c ? iss_sub_c : '0;
      {rd_addr3, rd_addr2, rd_addr1, rd_addr0} <= iss_c ? rd_addrs(iss_stage_c, iss_sub_c) : '0;
      // Write-back delay line: each read reappears as a write BF_LAT cycles later.
      pipe[0] <= {rd_en, rd_addr3, rd_addr2, rd_addr1, rd_addr0};
      for (int i = 1; i < BF_LAT; i++) pipe[i] <= pipe[i-1];
      done <= 1'b0;

      case (state)
        IDLE: if (start) begin
          state <= RUN;
          stg   <= '0;
          j     <= '0;
          busy  <= 1'b1;
        end
        RUN: if (j == 6'd63) begin
          state <= DRAIN;
          dcnt  <= '0;
        end else begin
          j <= j + 6'd1;
        end
        DRAIN: if (dcnt == DRAIN_LAST) begin
          if (stg != 2'd3) begin
            state <= RUN;
            stg   <= stg + 2'd1;
            j     <= '0;
          end else begin
            state <= OUT;
            c     <= '0;
          end
        end else begin
          dcnt <= dcnt + 4'd1;
        end
        OUT: begin
          ob_valid <= 1'b1;
          if (ob_valid && ob_ready) begin
            if (c == 8'hFF) begin
              state    <= DONE;
              ob_valid <= 1'b0;
              ob_addr  <= '0;
              ob_last  <= 1'b0;
              done     <= 1'b1;
            end else begin
              c       <= c + 8'd1;
              ob_addr <= digit_rev(c + 8'd1);
              ob_last <= (c + 8'd1 == 8'hFF);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FFT_SEQ_CYCLE_CNT_EN
  logic [15:0] cyc_cnt;

  // Saturating per-frame cycle count, published when the last bin is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt      <= '0;
      frame_cycles <= '0;
    end else begin
      if (state == IDLE) begin
        if (start && !abort) cyc_cnt <= '0;
      end else if (cyc_cnt != 16'hFFFF) begin
        cyc_cnt <= cyc_cnt + 16'd1;
      end
      if (hs_last_c && !abort) frame_cycles <= cyc_cnt;
    end
  end
`else
  assign frame_cycles = '0;
`endif

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Scoreboard bench for fft_seq_ctrl: a frame-level model queues expected reads, writes, bins and done; a monitor consumes them.
module tb_fft_seq_ctrl;
  localparam int L = 2;

  logic clk = 1'b0, rst, start, abort, ob_ready;
  logic busy, rd_en, wr_en, ob_valid, ob_last, done;
  logic [7:0] rd_addr0, rd_addr1, rd_addr2, rd_addr3;
  logic [7:0] wr_addr0, wr_addr1, wr_addr2, wr_addr3;
  logic [1:0] stage;
  logic [5:0] sub_stage;
  logic [7:0] ob_addr;
  logic [15:0] frame_cycles;

  fft_seq_ctrl #(.BF_LAT(L)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .ob_ready(ob_ready),
    .busy(busy), .rd_en(rd_en), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .rd_addr2(rd_addr2), .rd_addr3(rd_addr3), .stage(stage), .sub_stage(sub_stage),
    .wr_en(wr_en), .wr_addr0(wr_addr0), .wr_addr1(wr_addr1), .wr_addr2(wr_addr2),
    .wr_addr3(wr_addr3), .ob_valid(ob_valid), .ob_addr(ob_addr), .ob_last(ob_last),
    .done(done), .frame_cycles(frame_cycles)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int t;
    int s;
    int j;
    logic [31:0] av;
  } acc_t;

  acc_t rd_q[$];
  acc_t wr_q[$];
  logic [7:0] ob_q[$];
  int checks = 0, errors = 0;
  int base = 0, done_exp = -1, done_cnt = 0, done_rel = -1;
  bit mon_en = 1'b0;

  task automatic check(input bit ok, input string nm, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Frame model: radix-4 stage s groups butterflies with stride 4^(3-s); readout is base-4 digit reversal.
  function automatic void push_frame();
    acc_t e;
    int off, a0, x, r;
    rd_q.delete(); wr_q.delete(); ob_q.delete();
    for (int s = 0; s < 4; s++) begin
      off = 1;
      for (int k = s; k < 3; k++) off = off * 4;
      for (int jj = 0; jj < 64; jj++) begin
        a0   = (jj / off) * (4 * off) + (jj % off);
        e.t  = 1 + s * (64 + L) + jj;
        e.s  = s;
        e.j  = jj;
        e.av = {8'(a0 + 3 * off), 8'(a0 + 2 * off), 8'(a0 + off), 8'(a0)};
        rd_q.push_back(e);
        e.t = e.t + L;
        wr_q.push_back(e);
      end
    end
    for (int cc = 0; cc < 256; cc++) begin
      x = cc; r = 0;
      for (int d = 0; d < 4; d++) begin
        r = r * 4 + x % 4;
        x = x / 4;
      end
      ob_q.push_back(8'(r));
    end
  endfunction

  // Monitor: pops expectations whenever the DUT presents a read, write, bin or done.
  always @(negedge clk) begin
    int rel;
    acc_t e;
    logic [7:0] oa;
    if (mon_en) begin
      rel = cyc - base;
      if (rd_en) begin
        if (rd_q.size() == 0) check(1'b0, "rd_unexpected", rel, 0);
        else begin
          e = rd_q.pop_front();
          check(rel == e.t, "rd_time", rel, e.t);
          check({stage, sub_stage} == 8'({e.s[1:0], e.j[5:0]}), "rd_stage_sub", {stage, sub_stage}, {e.s[1:0], e.j[5:0]});
          check({rd_addr3, rd_addr2, rd_addr1, rd_addr0} == e.av, "rd_addr", {rd_addr3, rd_addr2, rd_addr1, rd_addr0}, e.av);
        end
      end else begin
        check({stage, sub_stage, rd_addr3, rd_addr2, rd_addr1, rd_addr0} == '0, "rd_idle_zero",
              {stage, sub_stage, rd_addr3, rd_addr2, rd_addr1, rd_addr0}, 0);
      end
      if (wr_en) begin
        if (wr_q.size() == 0) check(1'b0, "wr_unexpected", rel, 0);
        else begin
          e = wr_q.pop_front();
          check(rel == e.t, "wr_time", rel, e.t);
          check({wr_addr3, wr_addr2, wr_addr1, wr_addr0} == e.av, "wr_addr", {wr_addr3, wr_addr2, wr_addr1, wr_addr0}, e.av);
        end
      end else begin
        check({wr_addr3, wr_addr2, wr_addr1, wr_addr0} == '0, "wr_idle_zero", {wr_addr3, wr_addr2, wr_addr1, wr_addr0}, 0);
      end
      if (ob_valid && ob_ready) begin
        if (ob_q.size() == 0) check(1'b0, "ob_unexpected", ob_addr, 0);
        else begin
          oa = ob_q.pop_front();
          check(ob_addr == oa, "ob_addr", ob_addr, oa);
          check(ob_last == (ob_q.size() == 0), "ob_last", ob_last, ob_q.size() == 0);
          if (ob_q.size() == 0) done_exp = rel + 1;
        end
      end else if (ob_valid) begin
        if (ob_q.size() > 0) check(ob_addr == ob_q[0], "ob_hold", ob_addr, ob_q[0]);
      end else begin
        check({ob_addr, ob_last} == '0, "ob_idle_zero", {ob_addr, ob_last}, 0);
      end
      if (done) begin
        check(done_exp >= 0 && rel == done_exp, "done_time", rel, done_exp);
        done_cnt++;
        done_rel = rel;
        done_exp = -1;
      end
      if (rd_en || wr_en || ob_valid || done) check(busy == 1'b1, "busy_active", busy, 1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stop the frame at relative cycle x by abort (use_rst=0) or reset (use_rst=1).
  task automatic kill_frame(input int x, input bit use_rst, input int d0);
    abort = !use_rst;
    rst   = use_rst;
    start = 1'b1;
    tick();
    abort = 1'b0; rst = 1'b0; start = 1'b0; ob_ready = 1'b0;
    while (rd_q.size() > 0 && rd_q[rd_q.size()-1].t > x) void'(rd_q.pop_back());
    while (wr_q.size() > 0 && wr_q[wr_q.size()-1].t > x) void'(wr_q.pop_back());
    ob_q.delete();
    done_exp = -1;
    @(negedge clk);
    check({busy, rd_en, wr_en, ob_valid, done} == '0, "kill_outputs_idle", {busy, rd_en, wr_en, ob_valid, done}, 0);
    if (use_rst) check(frame_cycles == 16'd0, "rst_frame_cycles", frame_cycles, 0);
    repeat (8) @(negedge clk);
    check(busy == 1'b0, "kill_busy", busy, 0);
    check(done_cnt == d0, "kill_no_done", done_cnt - d0, 0);
    check(rd_q.size() + wr_q.size() == 0, "kill_queue_drained", rd_q.size() + wr_q.size(), 0);
    tick();
  endtask

  // mode 0: ob_ready=1, 1: toggling, 2: random ready and stray starts.
  task automatic run_frame(input int mode, input int kill_at, input bit use_rst, input int req_done_rel);
    int d0;
    int exp_fc;
    bit fin;
    d0 = done_cnt;
    fin = 1'b0;
    base = cyc;
    push_frame();
    done_exp = -1;
    start = 1'b1;
    ob_ready = (mode == 0);
    for (int n = 0; n < 3000; n++) begin
      tick();
      if (done_cnt > d0) begin
        fin = 1'b1;
        break;
      end
      if (cyc - base == kill_at) begin
        kill_frame(kill_at, use_rst, d0);
        return;
      end
      start = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      case (mode)
        0: ob_ready = 1'b1;
        1: ob_ready = n[0];
        default: ob_ready = 1'($urandom_range(0, 1));
      endcase
    end
    start = 1'b0;
    ob_ready = 1'b0;
    check(fin, "done_timeout", fin, 1);
    if (req_done_rel > 0) check(done_rel == req_done_rel, "done_cycle", done_rel, req_done_rel);
    check(ob_q.size() + rd_q.size() + wr_q.size() == 0, "frame_queues_empty", ob_q.size() + rd_q.size() + wr_q.size(), 0);
`ifdef FFT_SEQ_CYCLE_CNT_EN
    exp_fc = done_rel - 2;
`else
    exp_fc = 0;
`endif
    check(frame_cycles == 16'(exp_fc), "frame_cycles", frame_cycles, exp_fc);
    repeat (3) tick();
    check(done_cnt == d0 + 1, "single_done", done_cnt - d0, 1);
    check(busy == 1'b0, "idle_after_done", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b1; abort = 1'b0; ob_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0; ob_ready = 1'b0;
    @(negedge clk);
    check({busy, rd_en, wr_en, ob_valid, ob_last, done, stage, sub_stage} == '0, "reset_ctrl",
          {busy, rd_en, wr_en, ob_valid, ob_last, done, stage, sub_stage}, 0);
    check({rd_addr0, rd_addr1, rd_addr2, rd_addr3, wr_addr0, wr_addr1, wr_addr2, wr_addr3, ob_addr, frame_cycles} == '0,
          "reset_data", frame_cycles, 0);
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (2) tick();
    check(busy == 1'b0, "idle_busy", busy, 0);

    run_frame(0, -1, 1'b0, 4 * (64 + L) + 256 + 2);
    run_frame(1, -1, 1'b0, 0);
    run_frame(0, 1 + 2 * (64 + L) + 64, 1'b0, 0);
    run_frame(0, -1, 1'b0, 4 * (64 + L) + 256 + 2);
    run_frame(2, int'($urandom_range(2, 500)), 1'b0, 0);
    run_frame(2, int'($urandom_range(2, 500)), 1'b1, 0);
    run_frame(2, -1, 1'b0, 0);
    run_frame(2, -1, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
